mem_lsu: RTL and testbench
==========================

MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 Parameter BITS_SIZE, default 32, data/address width.
REQ-002 Parameter SIZE_MEM_DATA, default 10, log2 of memory depth in words.
REQ-003 Parameter MEM_LATENCY, default 2, legal range 1..8, number of BUSY cycles per access.
REQ-004 i_clk  in  1  single clock, rising edge.
REQ-005 i_reset  in  1  reset, asynchronous, active-high.
REQ-006 i_step  in  1  advance enable; when low the FSM, counter, memory writes and outputs other than o_mem_dato_debug freeze.
REQ-007 i_exmem_alu  in  BITS_SIZE  byte address.
REQ-008 i_exmem_mem_read  in  1  load request.
REQ-009 i_exmem_mem_write  in  1  store request.
REQ-010 i_exmem_mem_register2  in  BITS_SIZE  store data (rt).
REQ-011 i_exmem_size_filter  in  2  00 byte, 01 halfword, 11 word, 10 treated as word.
REQ-012 i_exmem_unsigned  in  1  1 zero-extends loads, 0 sign-extends.
REQ-013 i_addr_mem_debug  in  BITS_SIZE  debug byte address.
REQ-014 o_mem_dato  out  BITS_SIZE  extended load result.
REQ-015 o_mem_valid  out  1  access complete.
REQ-016 o_stall  out  1  access in progress; upstream holds.
REQ-017 o_misaligned  out  1  misaligned request rejected.
REQ-018 o_mem_dato_debug  out  BITS_SIZE  registered debug word.

Function
REQ-019 FSM states IDLE, BUSY, DONE; requests accepted only in IDLE or DONE at an edge with i_step=1.
REQ-020 Request = read or write high; both high is a store, read ignored.
REQ-021 Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0; misaligned request: no memory access, o_misaligned=1 for one step cycle, next state IDLE, o_mem_valid=0.
REQ-022 Aligned request at edge E0: address, data, size, unsigned, type captured; counter=MEM_LATENCY-1; state BUSY; o_stall=1.
REQ-023 BUSY: counter decrements each step edge; at the step edge with counter=0 the access executes, state DONE, o_stall=0, o_mem_valid=1.
REQ-024 With i_step held high, o_stall is high for exactly MEM_LATENCY cycles and o_mem_valid high for exactly one cycle, MEM_LATENCY+1 cycles after E0.
REQ-025 DONE with no new request returns to IDLE and clears o_mem_valid; DONE with new request behaves as IDLE acceptance (back-to-back throughput one access per MEM_LATENCY+1 cycles).
REQ-026 Memory word index = addr[SIZE_MEM_DATA+1:2]; higher bits ignored (wrap modulo depth).
REQ-027 Little-endian lanes: byte store writes only lane addr[1:0] with rt[7:0]; halfword store writes lanes addr[1]*2..+1 with rt[15:0]; word store writes all lanes; unwritten lanes unchanged.
REQ-028 Loads select the same lanes and extend to BITS_SIZE per i_exmem_unsigned; result registered into o_mem_dato at the access edge.
REQ-029 Stores leave o_mem_dato at its previous value.
REQ-030 o_mem_dato_debug updates every clock edge regardless of i_step, with word index i_addr_mem_debug[SIZE_MEM_DATA+1:2]; same-edge store to that word returns pre-store data.
REQ-031 Memory contents are not cleared by reset.

Reset
REQ-032 Asserting i_reset immediately forces state IDLE, counter 0, o_mem_dato=0, o_mem_valid=0, o_stall=0, o_misaligned=0, o_mem_dato_debug=0.
REQ-033 Reset during BUSY abandons the pending access; a pending store does not write.

Verification
REQ-034 MEM_LATENCY=2, step=1: word store 0xDEADBEEF to 0x10, then word load 0x10 -> o_stall high 2 cycles each, o_mem_valid 3 cycles after acceptance, o_mem_dato=0xDEADBEEF.
REQ-035 Byte store 0x7F to 0x13 over 0x00000000, then signed byte load 0x13 after byte store 0x80 -> word reads 0x7F000000; load returns 0xFFFFFF80, unsigned 0x00000080.
REQ-036 Halfword load at 0x11 and word load at 0x12 -> o_misaligned pulse, no o_mem_valid, memory unchanged.
REQ-037 i_step low for 5 cycles mid-BUSY -> o_stall stays 1, counter frozen, completion delayed exactly 5 cycles.
REQ-038 i_reset asserted mid-store -> outputs zero asynchronously; subsequent debug read of target word shows old value.
REQ-039 Debug address 0x10 with i_step=0 -> o_mem_dato_debug=0xDEADBEEF one cycle later; address 0x1010 with SIZE_MEM_DATA=10 aliases to word 4.

Source files
------------

// File: rtl/mem_lsu.sv
// mem_lsu: multi-cycle load/store unit for the MEM pipeline stage.
// One request at a time: accept, wait MEM_LATENCY step cycles in BUSY,
// then perform the memory access and report it for one cycle in DONE.
// Byte-lane writes, sign/zero-extended loads and a free-running debug
// read port that ignores i_step.
module mem_lsu #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_MEM_DATA = 10,
  parameter int MEM_LATENCY   = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic [BITS_SIZE-1:0] i_exmem_alu,
  input  logic                 i_exmem_mem_read,
  input  logic                 i_exmem_mem_write,
  input  logic [BITS_SIZE-1:0] i_exmem_mem_register2,
  input  logic [1:0]           i_exmem_size_filter,
  input  logic                 i_exmem_unsigned,
  input  logic [BITS_SIZE-1:0] i_addr_mem_debug,
  output logic [BITS_SIZE-1:0] o_mem_dato,
  output logic                 o_mem_valid,
  output logic                 o_stall,
  output logic                 o_misaligned,
  output logic [BITS_SIZE-1:0] o_mem_dato_debug
);

  // Handshake: a request (read or write high) is taken at a rising edge with
  // i_step=1 while the FSM is IDLE or DONE. An aligned request raises o_stall
  // from that edge until the access edge; the upstream stage must hold while
  // o_stall is high. o_mem_valid is high for exactly one step cycle after the
  // access edge, carrying the load result on o_mem_dato. A misaligned request
  // is dropped and flagged on o_misaligned for one step cycle instead.

  localparam int DEPTH = 1 << SIZE_MEM_DATA;
  localparam int AW    = SIZE_MEM_DATA + 2;
  localparam logic [2:0] CNT_INIT = 3'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // FSM state and latency counter
  state_t     r_state;
  state_t     w_state_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_next;

  // Captured request
  logic [AW-1:0]        r_addr;
  logic [BITS_SIZE-1:0] r_data;
  logic [1:0]           r_size;
  logic                 r_unsigned;
  logic                 r_write;

  // Storage and registered outputs
  logic [BITS_SIZE-1:0] r_mem [0:DEPTH-1];
  logic [BITS_SIZE-1:0] r_mem_dato;
  logic [BITS_SIZE-1:0] r_dbg;
  logic                 r_valid;
  logic                 r_stall;
  logic                 r_misaligned;

  // Decode and datapath wires
  logic                     w_req;
  logic                     w_misaligned;
  logic                     w_accept;
  logic                     w_reject;
  logic                     w_access;
  logic [SIZE_MEM_DATA-1:0] w_idx;
  logic [SIZE_MEM_DATA-1:0] w_dbg_idx;
  logic [4:0]               w_shift;
  logic [BITS_SIZE-1:0]     w_lane_mask;
  logic [BITS_SIZE-1:0]     w_rword;
  logic [BITS_SIZE-1:0]     w_wword;
  logic [BITS_SIZE-1:0]     w_rshift;
  logic [BITS_SIZE-1:0]     w_load_ext;
  logic                     w_unused;

  // Address bits above the memory depth are ignored (accesses wrap).
  assign w_unused = ^{i_exmem_alu[BITS_SIZE-1:AW],
                      i_addr_mem_debug[BITS_SIZE-1:AW],
                      i_addr_mem_debug[1:0]};

  assign w_req     = i_exmem_mem_read | i_exmem_mem_write;
  assign w_idx     = r_addr[AW-1:2];
  assign w_dbg_idx = i_addr_mem_debug[AW-1:2];
  assign w_rword   = r_mem[w_idx];

  // Alignment check on the incoming request (size 10 behaves as word)
  always_comb begin
    w_misaligned = 1'b0;
    case (i_exmem_size_filter)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = i_exmem_alu[0];
      default: w_misaligned = (i_exmem_alu[1:0] != 2'b00);
    endcase
  end

  // Next-state logic: accept/reject in IDLE or DONE, count down in BUSY
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    w_access     = 1'b0;
    if (i_step) begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_req && w_misaligned) begin
            w_reject     = 1'b1;
            w_state_next = ST_IDLE;
            w_cnt_next   = 3'd0;
          end else if (w_req) begin
            w_accept     = 1'b1;
            w_state_next = ST_BUSY;
            w_cnt_next   = CNT_INIT;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (r_cnt == 3'd0) begin
            w_access     = 1'b1;
            w_state_next = ST_DONE;
          end else begin
            w_cnt_next = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_next = ST_IDLE;
          w_cnt_next   = 3'd0;
        end
      endcase
    end
  end

  // State and counter register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Capture the request fields at acceptance; BUSY works from these copies
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_addr     <= '0;
      r_data     <= '0;
      r_size     <= 2'b00;
      r_unsigned <= 1'b0;
      r_write    <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= i_exmem_alu[AW-1:0];
      r_data     <= i_exmem_mem_register2;
      r_size     <= i_exmem_size_filter;
      r_unsigned <= i_exmem_unsigned;
      r_write    <= i_exmem_mem_write;
    end
  end

  // Lane shift and byte-enable mask from captured size and low address bits
  always_comb begin
    w_shift     = 5'd0;
    w_lane_mask = '1;
    case (r_size)
      2'b00: begin
        w_shift     = {r_addr[1:0], 3'b000};
        w_lane_mask = {{(BITS_SIZE-8){1'b0}}, 8'hFF} << w_shift;
      end
      2'b01: begin
        w_shift     = {r_addr[1], 4'b0000};
        w_lane_mask = {{(BITS_SIZE-16){1'b0}}, 16'hFFFF} << w_shift;
      end
      default: begin
        w_shift     = 5'd0;
        w_lane_mask = '1;
      end
    endcase
  end

  // Store merges new lanes into the existing word; loads shift down
  assign w_wword  = (w_rword & ~w_lane_mask) | ((r_data << w_shift) & w_lane_mask);
  assign w_rshift = w_rword >> w_shift;

  // Load extension to full width
  always_comb begin
    w_load_ext = w_rshift;
    case (r_size)
      2'b00: begin
        if (r_unsigned) w_load_ext = {{(BITS_SIZE-8){1'b0}}, w_rshift[7:0]};
        else            w_load_ext = {{(BITS_SIZE-8){w_rshift[7]}}, w_rshift[7:0]};
      end
      2'b01: begin
        if (r_unsigned) w_load_ext = {{(BITS_SIZE-16){1'b0}}, w_rshift[15:0]};
        else            w_load_ext = {{(BITS_SIZE-16){w_rshift[15]}}, w_rshift[15:0]};
      end
      default: w_load_ext = w_rshift;
    endcase
  end

  // Registered status and load result; everything holds while i_step is low
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mem_dato   <= '0;
      r_valid      <= 1'b0;
      r_stall      <= 1'b0;
      r_misaligned <= 1'b0;
    end else if (i_step) begin
      r_stall      <= (w_state_next == ST_BUSY);
      r_valid      <= w_access;
      r_misaligned <= w_reject;
      if (w_access && !r_write) begin
        r_mem_dato <= w_load_ext;
      end
    end
  end

  // Memory write port; contents survive reset, and reset forces IDLE so an
  // abandoned store never reaches this point
  always_ff @(posedge i_clk) begin
    if (w_access && r_write) begin
      r_mem[w_idx] <= w_wword;
    end
  end

  // Debug read port runs every edge; a same-edge store is seen next cycle
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_dbg <= '0;
    end else begin
      r_dbg <= r_mem[w_dbg_idx];
    end
  end

  assign o_mem_dato       = r_mem_dato;
  assign o_mem_valid      = r_valid;
  assign o_stall          = r_stall;
  assign o_misaligned     = r_misaligned;
  assign o_mem_dato_debug = r_dbg;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed tests for mem_lsu with default parameters
// (32-bit data, 1024 words, MEM_LATENCY=2).
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic [31:0] alu;
  logic        rd;
  logic        wr;
  logic [31:0] rt;
  logic [1:0]  sz;
  logic        uns;
  logic [31:0] dbg_addr;
  logic [31:0] o_mem_dato;
  logic        o_mem_valid;
  logic        o_stall;
  logic        o_misaligned;
  logic [31:0] o_mem_dato_debug;

  int checks = 0;
  int errors = 0;

  int          ns, nv, va;
  logic [31:0] dv, prev;

  mem_lsu dut (
    .i_clk                 (clk),
    .i_reset               (rst),
    .i_step                (step),
    .i_exmem_alu           (alu),
    .i_exmem_mem_read      (rd),
    .i_exmem_mem_write     (wr),
    .i_exmem_mem_register2 (rt),
    .i_exmem_size_filter   (sz),
    .i_exmem_unsigned      (uns),
    .i_addr_mem_debug      (dbg_addr),
    .o_mem_dato            (o_mem_dato),
    .o_mem_valid           (o_mem_valid),
    .o_stall               (o_stall),
    .o_misaligned          (o_misaligned),
    .o_mem_dato_debug      (o_mem_dato_debug)
  );

  // clock
  always #5 clk = ~clk;

  // advance one edge, then sit 1ns past it for sampling and driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: issue one request, then observe 6 cycles after the accepting edge
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            input logic u, input logic w, output int n_stall,
                            output int n_valid, output int valid_at, output logic [31:0] dato);
    alu = a; rt = d; sz = s; uns = u; wr = w; rd = !w;
    tick();
    rd = 1'b0; wr = 1'b0;
    n_stall = 0; n_valid = 0; valid_at = -1; dato = o_mem_dato;
    for (int c = 1; c <= 6; c++) begin
      if (o_stall === 1'b1) n_stall++;
      if (o_mem_valid === 1'b1) begin
        n_valid++;
        if (valid_at < 0) begin
          valid_at = c;
          dato = o_mem_dato;
        end
      end
      if (c < 6) tick();
    end
  endtask

  task automatic test_reset();
    step = 1'b0; rd = 1'b0; wr = 1'b0; alu = '0; rt = '0; sz = 2'b11; uns = 1'b0; dbg_addr = '0;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (o_mem_dato !== 32'h0) begin errors++; $display("FAIL reset_dato: got %h expected %h", o_mem_dato, 32'h0); end
    checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_mem_valid); end
    checks++; if (o_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", o_stall); end
    checks++; if (o_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", o_misaligned); end
    checks++; if (o_mem_dato_debug !== 32'h0) begin errors++; $display("FAIL reset_debug: got %h expected %h", o_mem_dato_debug, 32'h0); end
    tick(); tick();
    rst = 1'b0; step = 1'b1;
    tick();
  endtask

  task automatic test_word();
    prev = o_mem_dato;
    run_access(32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 1'b1, ns, nv, va, dv);
    checks++; if (ns !== 2) begin errors++; $display("FAIL word_store_stall: got %0d expected 2", ns); end
    checks++; if (va !== 3) begin errors++; $display("FAIL word_store_valid_at: got %0d expected 3", va); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL word_store_valid_len: got %0d expected 1", nv); end
    checks++; if (dv !== prev) begin errors++; $display("FAIL word_store_dato_kept: got %h expected %h", dv, prev); end
    run_access(32'h10, 32'h0, 2'b11, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (ns !== 2) begin errors++; $display("FAIL word_load_stall: got %0d expected 2", ns); end
    checks++; if (va !== 3) begin errors++; $display("FAIL word_load_valid_at: got %0d expected 3", va); end
    checks++; if (nv !== 1) begin errors++; $display("FAIL word_load_valid_len: got %0d expected 1", nv); end
    checks++; if (dv !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load_data: got %h expected %h", dv, 32'hDEADBEEF); end
  endtask

  task automatic test_debug();
    step = 1'b0;
    dbg_addr = 32'h10;
    tick();
    checks++; if (o_mem_dato_debug !== 32'hDEADBEEF) begin errors++; $display("FAIL debug_no_step: got %h expected %h", o_mem_dato_debug, 32'hDEADBEEF); end
    dbg_addr = 32'h1010;
    tick();
    checks++; if (o_mem_dato_debug !== 32'hDEADBEEF) begin errors++; $display("FAIL debug_alias: got %h expected %h", o_mem_dato_debug, 32'hDEADBEEF); end
    step = 1'b1;
    dbg_addr = 32'h10;
    alu = 32'h10; rt = 32'h01020304; sz = 2'b11; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
    tick();
    checks++; if (o_mem_valid !== 1'b1) begin errors++; $display("FAIL debug_store_valid: got %b expected 1", o_mem_valid); end
    checks++; if (o_mem_dato_debug !== 32'hDEADBEEF) begin errors++; $display("FAIL debug_same_edge: got %h expected %h", o_mem_dato_debug, 32'hDEADBEEF); end
    tick();
    checks++; if (o_mem_dato_debug !== 32'h01020304) begin errors++; $display("FAIL debug_after_store: got %h expected %h", o_mem_dato_debug, 32'h01020304); end
  endtask

  task automatic test_bytes();
    dbg_addr = 32'h10;
    run_access(32'h10, 32'h0, 2'b11, 1'b0, 1'b1, ns, nv, va, dv);
    run_access(32'h13, 32'hAAAAAA7F, 2'b00, 1'b0, 1'b1, ns, nv, va, dv);
    checks++; if (o_mem_dato_debug !== 32'h7F000000) begin errors++; $display("FAIL byte_store_7f: got %h expected %h", o_mem_dato_debug, 32'h7F000000); end
    run_access(32'h13, 32'h12345680, 2'b00, 1'b0, 1'b1, ns, nv, va, dv);
    checks++; if (o_mem_dato_debug !== 32'h80000000) begin errors++; $display("FAIL byte_store_80: got %h expected %h", o_mem_dato_debug, 32'h80000000); end
    run_access(32'h11, 32'hFFFFFF5A, 2'b00, 1'b0, 1'b1, ns, nv, va, dv);
    checks++; if (o_mem_dato_debug !== 32'h80005A00) begin errors++; $display("FAIL byte_store_lane1: got %h expected %h", o_mem_dato_debug, 32'h80005A00); end
    run_access(32'h13, 32'h0, 2'b00, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_load_signed: got %h expected %h", dv, 32'hFFFFFF80); end
    run_access(32'h13, 32'h0, 2'b00, 1'b1, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'h00000080) begin errors++; $display("FAIL byte_load_unsigned: got %h expected %h", dv, 32'h00000080); end
    run_access(32'h11, 32'h0, 2'b00, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'h0000005A) begin errors++; $display("FAIL byte_load_lane1: got %h expected %h", dv, 32'h0000005A); end
    run_access(32'h10, 32'h0, 2'b00, 1'b1, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'h00000000) begin errors++; $display("FAIL byte_load_lane0: got %h expected %h", dv, 32'h00000000); end
  endtask

  task automatic test_halfword();
    dbg_addr = 32'h14;
    run_access(32'h14, 32'h11223344, 2'b11, 1'b0, 1'b1, ns, nv, va, dv);
    run_access(32'h16, 32'hFFFFA5C3, 2'b01, 1'b0, 1'b1, ns, nv, va, dv);
    checks++; if (o_mem_dato_debug !== 32'hA5C33344) begin errors++; $display("FAIL half_store: got %h expected %h", o_mem_dato_debug, 32'hA5C33344); end
    run_access(32'h16, 32'h0, 2'b01, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'hFFFFA5C3) begin errors++; $display("FAIL half_load_signed: got %h expected %h", dv, 32'hFFFFA5C3); end
    run_access(32'h16, 32'h0, 2'b01, 1'b1, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'h0000A5C3) begin errors++; $display("FAIL half_load_unsigned: got %h expected %h", dv, 32'h0000A5C3); end
    run_access(32'h14, 32'h0, 2'b01, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'h00003344) begin errors++; $display("FAIL half_load_low: got %h expected %h", dv, 32'h00003344); end
    run_access(32'h14, 32'h0, 2'b10, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'hA5C33344) begin errors++; $display("FAIL size10_as_word: got %h expected %h", dv, 32'hA5C33344); end
    run_access(32'h17, 32'h0, 2'b00, 1'b0, 1'b0, ns, nv, va, dv);
    checks++; if (dv !== 32'hFFFFFFA5) begin errors++; $display("FAIL byte_load_lane3: got %h expected %h", dv, 32'hFFFFFFA5); end
  endtask

  task automatic test_misaligned();
    dbg_addr = 32'h10;
    prev = o_mem_dato;
    alu = 32'h11; sz = 2'b01; uns = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_half_flag: got %b expected 1", o_misaligned); end
    checks++; if (o_mem_valid !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL mis_half_status: got valid=%b stall=%b expected 0 0", o_mem_valid, o_stall); end
    tick();
    checks++; if (o_misaligned !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL mis_half_pulse: got mis=%b valid=%b expected 0 0", o_misaligned, o_mem_valid); end
    alu = 32'h12; sz = 2'b11; rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_word_flag: got %b expected 1", o_misaligned); end
    tick();
    checks++; if (o_misaligned !== 1'b0 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL mis_word_pulse: got mis=%b valid=%b expected 0 0", o_misaligned, o_mem_valid); end
    alu = 32'h12; sz = 2'b11; rt = 32'hFFFFFFFF; wr = 1'b1;
    tick();
    wr = 1'b0;
    checks++; if (o_misaligned !== 1'b1) begin errors++; $display("FAIL mis_store_flag: got %b expected 1", o_misaligned); end
    tick(); tick(); tick();
    checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL mis_store_no_valid: got %b expected 0", o_mem_valid); end
    checks++; if (o_mem_dato_debug !== 32'h80005A00) begin errors++; $display("FAIL mis_store_mem: got %h expected %h", o_mem_dato_debug, 32'h80005A00); end
    checks++; if (o_mem_dato !== prev) begin errors++; $display("FAIL mis_dato_kept: got %h expected %h", o_mem_dato, prev); end
  endtask

  task automatic test_step_freeze();
    alu = 32'h14; sz = 2'b11; uns = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    step = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (o_stall !== 1'b1 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL freeze_%0d: got stall=%b valid=%b expected 1 0", i, o_stall, o_mem_valid); end
    end
    step = 1'b1;
    tick();
    checks++; if (o_stall !== 1'b1 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL freeze_resume: got stall=%b valid=%b expected 1 0", o_stall, o_mem_valid); end
    tick();
    checks++; if (o_mem_valid !== 1'b1 || o_stall !== 1'b0) begin errors++; $display("FAIL freeze_done: got valid=%b stall=%b expected 1 0", o_mem_valid, o_stall); end
    checks++; if (o_mem_dato !== 32'hA5C33344) begin errors++; $display("FAIL freeze_data: got %h expected %h", o_mem_dato, 32'hA5C33344); end
    tick();
    checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL freeze_valid_drop: got %b expected 0", o_mem_valid); end
  endtask

  task automatic test_back_to_back();
    alu = 32'h14; sz = 2'b11; uns = 1'b0; rd = 1'b1;
    tick();
    rd = 1'b0;
    tick();
    tick();
    checks++; if (o_mem_valid !== 1'b1 || o_mem_dato !== 32'hA5C33344) begin errors++; $display("FAIL b2b_first: got valid=%b data=%h expected 1 %h", o_mem_valid, o_mem_dato, 32'hA5C33344); end
    alu = 32'h10; rd = 1'b1;
    tick();
    rd = 1'b0;
    checks++; if (o_stall !== 1'b1 || o_mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept_done: got stall=%b valid=%b expected 1 0", o_stall, o_mem_valid); end
    tick();
    checks++; if (o_stall !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b expected 1", o_stall); end
    tick();
    checks++; if (o_mem_valid !== 1'b1 || o_mem_dato !== 32'h80005A00) begin errors++; $display("FAIL b2b_second: got valid=%b data=%h expected 1 %h", o_mem_valid, o_mem_dato, 32'h80005A00); end
    tick();
    checks++; if (o_mem_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", o_mem_valid); end
  endtask

  task automatic test_reset_mid_store();
    run_access(32'h20, 32'h0BADF00D, 2'b11, 1'b0, 1'b1, ns, nv, va, dv);
    dbg_addr = 32'h20;
    alu = 32'h20; rt = 32'h55555555; sz = 2'b11; wr = 1'b1;
    tick();
    wr = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (o_stall !== 1'b0 || o_mem_valid !== 1'b0 || o_misaligned !== 1'b0) begin errors++; $display("FAIL midrst_status: got stall=%b valid=%b mis=%b expected 0 0 0", o_stall, o_mem_valid, o_misaligned); end
    checks++; if (o_mem_dato !== 32'h0) begin errors++; $display("FAIL midrst_dato: got %h expected %h", o_mem_dato, 32'h0); end
    checks++; if (o_mem_dato_debug !== 32'h0) begin errors++; $display("FAIL midrst_debug: got %h expected %h", o_mem_dato_debug, 32'h0); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (o_mem_dato_debug !== 32'h0BADF00D) begin errors++; $display("FAIL midrst_mem_kept: got %h expected %h", o_mem_dato_debug, 32'h0BADF00D); end
    checks++; if (o_mem_valid !== 1'b0 || o_stall !== 1'b0) begin errors++; $display("FAIL midrst_after: got valid=%b stall=%b expected 0 0", o_mem_valid, o_stall); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_debug();
    test_bytes();
    test_halfword();
    test_misaligned();
    test_step_freeze();
    test_back_to_back();
    test_reset_mid_store();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
